// File: rtl/clause_table.sv
// Clause table: an append-only store of clause indices with bounds-checked,
// one-cycle-latency reads. Entries are filled strictly in order by push and
// can only be discarded all at once by reset.

`ifndef CLAUSE_TABLE_BITS
`define CLAUSE_TABLE_BITS 5
`endif

`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module clause_table #(
    parameter int CLAUSE_TABLE_BITS = `CLAUSE_TABLE_BITS,
    parameter int MAX_CLAUSES_BITS  = `MAX_CLAUSES_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         read,
    input  logic [CLAUSE_TABLE_BITS-1:0] index_in,
    input  logic [MAX_CLAUSES_BITS-1:0]  clause_in,
    output logic [MAX_CLAUSES_BITS-1:0]  clause_index_out,
    output logic                         full,
    output logic                         error
);

    localparam int DEPTH = 2 ** CLAUSE_TABLE_BITS;
    localparam logic [CLAUSE_TABLE_BITS:0] DEPTH_COUNT = (CLAUSE_TABLE_BITS + 1)'(DEPTH);

    logic [MAX_CLAUSES_BITS-1:0]  entries [DEPTH];
    logic [CLAUSE_TABLE_BITS:0]   count;
    logic                         push_ok;
    logic                         read_ok;

    // Legality of both operations is judged against the count held before
    // this edge, so a same-cycle push never makes its own slot readable.
    assign push_ok = push && (count != DEPTH_COUNT);
    assign read_ok = read && ({1'b0, index_in} < count);
    assign full    = (count == DEPTH_COUNT);

    // Storage write. No reset term: a write landing while reset is held can
    // only target entry 0 with count forced to 0, so it is never observable
    // and is overwritten by the first real push.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            entries[count[CLAUSE_TABLE_BITS-1:0]] <= clause_in;
        end
    end

    // Fill count, registered read data and per-cycle error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count            <= '0;
            clause_index_out <= '0;
            error            <= 1'b0;
        end else begin
            if (push_ok) begin
                count <= count + 1'b1;
            end
            // Output holds on idle cycles; an out-of-range read returns zero.
            if (read) begin
                clause_index_out <= read_ok ? entries[index_in] : '0;
            end
            error <= (push && !push_ok) || (read && !read_ok);
        end
    end

endmodule

// File: tb/tb_clause_table.sv
// Directed testbench for clause_table: fill, boundary reads, full/overflow,
// same-cycle push+read, and asynchronous reset behaviour.

module tb_clause_table;

    logic       clock;
    logic       reset;
    logic       push;
    logic       read;
    logic [4:0] index_in;
    logic [7:0] clause_in;
    logic [7:0] clause_index_out;
    logic       full;
    logic       error;

    int total = 0;
    int bad   = 0;

    clause_table dut (
        .clock            (clock),
        .reset            (reset),
        .push             (push),
        .read             (read),
        .index_in         (index_in),
        .clause_in        (clause_in),
        .clause_index_out (clause_index_out),
        .full             (full),
        .error            (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Value pushed as the i-th entry of the main fill.
    function automatic logic [7:0] v(input int i);
        return 8'(i * 9 + 17);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        read      = 1'b0;
        index_in  = '0;
        clause_in = '0;

        // Reset state
        #2;
        check("rst_out",   32'(clause_index_out), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_full",  32'(full),  32'h0);

        // Push attempted while reset is high is ignored
        push      = 1'b1;
        clause_in = 8'h99;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push  = 1'b0;

        // Read 7 on empty table
        read     = 1'b1;
        index_in = 5'd7;
        step();
        check("empty_rd7_error", 32'(error), 32'h1);
        check("empty_rd7_out",   32'(clause_index_out), 32'h0);
        check("empty_rd7_full",  32'(full), 32'h0);

        // Push V0..V24
        read = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 25; i++) begin
            clause_in = v(i);
            step();
            check($sformatf("fill25_error_%0d", i), 32'(error), 32'h0);
            check($sformatf("fill25_full_%0d", i),  32'(full),  32'h0);
        end
        push = 1'b0;

        // Reads inside the filled range
        read     = 1'b1;
        index_in = 5'd24;
        step();
        check("rd24_out",   32'(clause_index_out), 32'(v(24)));
        check("rd24_error", 32'(error), 32'h0);
        index_in = 5'd23;
        step();
        check("rd23_out",   32'(clause_index_out), 32'(v(23)));
        check("rd23_error", 32'(error), 32'h0);

        // Out-of-range reads, including the count boundary
        index_in = 5'd30;
        step();
        check("rd30_error", 32'(error), 32'h1);
        check("rd30_out",   32'(clause_index_out), 32'h0);
        index_in = 5'd25;
        step();
        check("rd25_error", 32'(error), 32'h1);
        check("rd25_out",   32'(clause_index_out), 32'h0);

        // Idle cycle: error clears, output holds
        read = 1'b0;
        step();
        check("idle_error", 32'(error), 32'h0);
        check("idle_out",   32'(clause_index_out), 32'h0);

        // Fill to 32 entries
        push = 1'b1;
        for (int i = 25; i < 32; i++) begin
            clause_in = v(i);
            step();
            check($sformatf("fill32_error_%0d", i), 32'(error), 32'h0);
            check($sformatf("fill32_full_%0d", i),  32'(full), (i == 31) ? 32'h1 : 32'h0);
        end

        // 33rd push overflows
        clause_in = 8'hEE;
        step();
        check("ovf_error", 32'(error), 32'h1);
        check("ovf_full",  32'(full),  32'h1);

        // Last entry still holds the 32nd value
        push     = 1'b0;
        read     = 1'b1;
        index_in = 5'd31;
        step();
        check("rd31_out",   32'(clause_index_out), 32'(v(31)));
        check("rd31_error", 32'(error), 32'h0);
        index_in = 5'd0;
        step();
        check("rd0_out", 32'(clause_index_out), 32'(v(0)));

        // Overflowing push together with a legal read
        push      = 1'b1;
        clause_in = 8'hFF;
        index_in  = 5'd31;
        step();
        check("ovf_rd_error", 32'(error), 32'h1);
        check("ovf_rd_out",   32'(clause_index_out), 32'(v(31)));
        check("ovf_rd_full",  32'(full), 32'h1);

        // Asynchronous reset between edges while full
        push = 1'b0;
        read = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_full_out",   32'(clause_index_out), 32'h0);
        check("async_full_error", 32'(error), 32'h0);
        check("async_full_full",  32'(full),  32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Three entries, then same-cycle push and read of slot 3
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clause_in = 8'(8'h30 + i);
            step();
        end
        clause_in = 8'h5A;
        read      = 1'b1;
        index_in  = 5'd3;
        step();
        check("pr3_error", 32'(error), 32'h1);
        check("pr3_out",   32'(clause_index_out), 32'h0);
        push = 1'b0;
        step();
        check("rd3_out",   32'(clause_index_out), 32'h5A);
        check("rd3_error", 32'(error), 32'h0);
        index_in = 5'd1;
        step();
        check("rd1_out", 32'(clause_index_out), 32'h31);

        // Grow to 10 entries, read the last one
        read = 1'b0;
        push = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clause_in = 8'(8'h60 + i);
            step();
        end
        push     = 1'b0;
        read     = 1'b1;
        index_in = 5'd9;
        step();
        check("rd9_out",   32'(clause_index_out), 32'h65);
        check("rd9_error", 32'(error), 32'h0);

        // Asynchronous reset mid-cycle with 10 entries; push held during reset
        read = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async10_out",   32'(clause_index_out), 32'h0);
        check("async10_error", 32'(error), 32'h0);
        check("async10_full",  32'(full),  32'h0);
        push      = 1'b1;
        clause_in = 8'h77;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push  = 1'b0;

        // Everything discarded: read 0 is illegal
        read     = 1'b1;
        index_in = 5'd0;
        step();
        check("post_rst_rd0_error", 32'(error), 32'h1);
        check("post_rst_rd0_out",   32'(clause_index_out), 32'h0);
        check("post_rst_full",      32'(full), 32'h0);

        // Fresh push lands at entry 0
        read      = 1'b0;
        push      = 1'b1;
        clause_in = 8'h42;
        step();
        check("refill_error", 32'(error), 32'h0);
        push = 1'b0;
        read = 1'b1;
        step();
        check("refill_rd0_out",   32'(clause_index_out), 32'h42);
        check("refill_rd0_error", 32'(error), 32'h0);
        index_in = 5'd1;
        step();
        check("refill_rd1_error", 32'(error), 32'h1);
        read = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clause_table.md
CLAUSE_TABLE -- requirements
Module: clause_table

Interface
REQ-001 Parameter CLAUSE_TABLE_BITS, default `CLAUSE_TABLE_BITS (5), index width; table depth DEPTH = 2**CLAUSE_TABLE_BITS (32).
REQ-002 Parameter MAX_CLAUSES_BITS, default `MAX_CLAUSES_BITS (8), width of a stored clause index.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 push  input  1  append clause_in at the next free entry.
REQ-006 read  input  1  read the entry addressed by index_in.
REQ-007 index_in  input  CLAUSE_TABLE_BITS  read address.
REQ-008 clause_in  input  MAX_CLAUSES_BITS  value to append.
REQ-009 clause_index_out  output  MAX_CLAUSES_BITS  registered read data.
REQ-010 full  output  1  table holds DEPTH entries.
REQ-011 error  output  1  registered flag: previous cycle's operation was illegal.

Function
REQ-012 Storage: DEPTH x MAX_CLAUSES_BITS array plus a count register, width CLAUSE_TABLE_BITS+1, range 0..DEPTH.
REQ-013 Entries are written only by push, in order, at address count; no delete or overwrite.
REQ-014 Push with count < DEPTH: entry[count] <= clause_in, count <= count+1 at the clock edge.
REQ-015 Push with count == DEPTH: no write, count unchanged, error = 1 next cycle.
REQ-016 Read with index_in < count: clause_index_out <= entry[index_in]; one-cycle latency, valid the cycle after the request.
REQ-017 Read with index_in >= count, including read on an empty table and index_in == count: clause_index_out <= 0, error = 1 next cycle.
REQ-018 The read legality check uses count before the same-edge push; a same-cycle push never makes a read of the entry being written legal.
REQ-019 Simultaneous push and read: both are evaluated independently; error = OR of both illegal conditions.
REQ-020 Cycle with neither push nor read: clause_index_out holds its last value; error = 0.
REQ-021 error is not sticky; it reflects only the immediately preceding cycle's operation.
REQ-022 full is combinational: full = (count == DEPTH).
REQ-023 index_in and clause_in are don't-care when read and push, respectively, are low; X on these inputs shall not corrupt state.

Reset
REQ-024 Reset asserted asynchronously forces count = 0, clause_index_out = 0, error = 0, and full = 0, regardless of clock.
REQ-025 Array contents need not be cleared; with count = 0, every entry is unreadable.
REQ-026 Push or read while reset is high is ignored.
REQ-027 Operation resumes at the first rising edge after reset deasserts.
REQ-028 Reset mid-fill discards all prior entries logically; subsequent pushes start at entry 0.

Verification
REQ-029 Reset, then read index_in = 7 on the empty table -> next cycle error = 1, clause_index_out = 0, full = 0.
REQ-030 Push 25 values V0..V24 on consecutive cycles -> error = 0 throughout, full = 0; then read 24 -> V24 and read 23 -> V23, each one cycle later with error = 0.
REQ-031 With 25 entries, read 30 -> error = 1 and out = 0; read 25 (boundary) -> error = 1 and out = 0.
REQ-032 Push 32 values -> full = 1 after the 32nd edge; a 33rd push -> error = 1, count stays 32, and reading 31 returns the 32nd value.
REQ-033 With 3 entries, assert push and read 3 in the same cycle -> error = 1 and out = 0; the push is stored, and reading 3 the next cycle returns the pushed value.
REQ-034 Assert reset asynchronously, between clock edges, while 10 entries are stored -> full, error and out drop to 0 immediately; reading 0 after release -> error = 1.
